// File: rtl/cram_save_ctrl.sv
// Moves cart RAM to and from the SD save file one 512-byte sector at a time.
// Optional macro CRAM_SAVE_DIRTY_EN: only save after CPU writes to cart RAM.
module cram_save_ctrl #(
  parameter int LBA_W  = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              sav_supported,
  input  logic [LBA_W-1:0]  sav_last_lba,
  input  logic              img_mounted,
  input  logic [31:0]       img_size,
  input  logic              img_readonly,
  input  logic              save_req,
  input  logic              cram_cpu_wr,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  input  logic [8:0]        sd_buff_addr,
  input  logic [7:0]        sd_buff_dout,
  input  logic              sd_buff_wr,
  output logic [7:0]        sd_buff_din,
  output logic [ADDR_W-1:0] cram_addr,
  output logic              cram_we,
  output logic [7:0]        cram_din,
  input  logic [7:0]        cram_dout,
  output logic              cart_pause,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REQ  = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_SAVE_REQ  = 3'd3,
    S_SAVE_WAIT = 3'd4,
    S_NEXT      = 3'd5
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LBA_W-1:0]   r_lba, w_lba_nxt;
  logic               r_is_load;
  logic               r_mounted, r_ro;
  logic               r_load_pend, r_save_pend;
  logic               r_save_req_d;
  logic               r_sd_rd, r_sd_wr, r_pause, r_busy;
  logic               w_take_load, w_take_save, w_done;
  logic               w_save_ok;
  logic               w_save_rise;
  logic [LBA_W+8:0]   w_full_addr;

`ifdef CRAM_SAVE_DIRTY_EN
  logic r_dirty;

  // Dirty flag: a CPU write wins over the end-of-job clear in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_dirty <= 1'b0;
    end else if (cram_cpu_wr) begin
      r_dirty <= 1'b1;
    end else if (w_done) begin
      r_dirty <= 1'b0;
    end
  end

  assign w_save_ok = r_dirty;
`else
  logic w_unused_cpu_wr;
  assign w_unused_cpu_wr = cram_cpu_wr;
  assign w_save_ok       = 1'b1;
`endif

  assign w_save_rise = save_req & ~r_save_req_d;

  // Next-state and sector-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_lba_nxt   = r_lba;
    w_take_load = 1'b0;
    w_take_save = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_load_pend) begin
          w_take_load = 1'b1;
          w_lba_nxt   = {LBA_W{1'b0}};
          w_state_nxt = S_LOAD_REQ;
        end else if (r_save_pend) begin
          w_take_save = 1'b1;
          w_lba_nxt   = {LBA_W{1'b0}};
          w_state_nxt = S_SAVE_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD_REQ:  w_state_nxt = sd_ack ? S_LOAD_WAIT : S_LOAD_REQ;
      S_SAVE_REQ:  w_state_nxt = sd_ack ? S_SAVE_WAIT : S_SAVE_REQ;
      S_LOAD_WAIT: w_state_nxt = sd_ack ? S_LOAD_WAIT : S_NEXT;
      S_SAVE_WAIT: w_state_nxt = sd_ack ? S_SAVE_WAIT : S_NEXT;
      S_NEXT: begin
        if (r_lba == sav_last_lba) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_lba_nxt   = r_lba + LBA_W'(1);
          w_state_nxt = r_is_load ? S_LOAD_REQ : S_SAVE_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lba     <= {LBA_W{1'b0}};
      r_is_load <= 1'b0;
      r_sd_rd   <= 1'b0;
      r_sd_wr   <= 1'b0;
      r_pause   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lba   <= w_lba_nxt;
      if (w_take_load) begin
        r_is_load <= 1'b1;
      end else if (w_take_save) begin
        r_is_load <= 1'b0;
      end
      r_sd_rd <= (w_state_nxt == S_LOAD_REQ);
      r_sd_wr <= (w_state_nxt == S_SAVE_REQ);
      r_busy  <= (w_state_nxt != S_IDLE);
      // Pause spans the NEXT cycle between sectors of a load as well.
      r_pause <= (w_state_nxt == S_LOAD_REQ) || (w_state_nxt == S_LOAD_WAIT) ||
                 ((w_state_nxt == S_NEXT) && r_is_load);
    end
  end

  // Job requests: later assignments win, so a new mount re-arms a load being taken.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_mounted    <= 1'b0;
      r_ro         <= 1'b0;
      r_load_pend  <= 1'b0;
      r_save_pend  <= 1'b0;
      r_save_req_d <= 1'b0;
    end else begin
      r_save_req_d <= save_req;
      if (w_take_load) begin
        r_load_pend <= 1'b0;
      end
      if (img_mounted) begin
        r_mounted   <= (img_size != 32'd0);
        r_ro        <= img_readonly;
        r_load_pend <= (img_size != 32'd0) & sav_supported;
      end
      if (w_take_save) begin
        r_save_pend <= 1'b0;
      end
      if (w_save_rise & r_mounted & ~r_ro & sav_supported & w_save_ok) begin
        r_save_pend <= 1'b1;
      end
    end
  end

  assign w_full_addr = {r_lba, sd_buff_addr};
  assign cram_addr   = ADDR_W'(w_full_addr);
  assign cram_we     = (r_state == S_LOAD_WAIT) & sd_buff_wr & sd_ack;
  assign cram_din    = sd_buff_dout;
  assign sd_buff_din = cram_dout;
  assign sd_lba      = 32'(r_lba);
  assign sd_rd       = r_sd_rd;
  assign sd_wr       = r_sd_wr;
  assign cart_pause  = r_pause;
  assign busy        = r_busy;

endmodule
